// File: rtl/retrosoc_rst_pkg.sv
// Shared types for the board-level reset conditioner: FSM states and reset cause codes.
package retrosoc_rst_pkg;

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        HOLD      = 2'd1,
        BTN_WAIT  = 2'd2,
        RUN       = 2'd3
    } rst_state_e;

    typedef enum logic [1:0] {
        RST_POR  = 2'd0,
        RST_LOCK = 2'd1,
        RST_BTN  = 2'd2,
        RST_SW   = 2'd3
    } rst_cause_e;

    localparam logic [7:0] RST_CNT_MAX = 8'hFF;

    function automatic logic [7:0] sat_inc(input logic [7:0] val);
        return (val == RST_CNT_MAX) ? val : val + 8'd1;
    endfunction

endpackage

// File: rtl/retrosoc_rst_debounce.sv
// Push-button synchroniser and debouncer; the debounced level only follows the raw
// input after DEB_CYCLES consecutive cycles of disagreement.
module retrosoc_rst_debounce #(
    parameter int SYNC_STAGES = 2,
    parameter int DEB_CYCLES  = 100000
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic btn_raw_n,
    output logic btn_deb_n
);
    localparam int CW = $clog2(DEB_CYCLES + 1);
    localparam logic [CW-1:0] DEB_LAST = CW'(DEB_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [CW-1:0]          cnt_q;
    logic                   deb_q;
    logic                   btn_sync;

    assign btn_sync = sync_q[SYNC_STAGES-1];

    // Synchroniser resets to "released" so a held button at power-up still needs a full debounce.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            sync_q <= '1;
            cnt_q  <= '0;
            deb_q  <= 1'b1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], btn_raw_n};
            if (btn_sync == deb_q) begin
                cnt_q <= '0;
            end else if (cnt_q == DEB_LAST) begin
                deb_q <= btn_sync;
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign btn_deb_n = deb_q;

endmodule

// File: rtl/retrosoc_rst_ctrl.sv
// Board reset conditioner: merges PLL lock, debounced button and software request into
// one clean clk_i-synchronous reset, and records the last cause and a warm-reset count.
//
//   state     | meaning
//   ----------+---------------------------------------------------------
//   WAIT_LOCK | reset asserted, waiting for LOCK_STABLE locked cycles
//   HOLD      | reset asserted, counting HOLD_CYCLES before release
//   BTN_WAIT  | reset asserted, waiting for the button to be released
//   RUN       | reset released, watching for lock loss / button / sw
module retrosoc_rst_ctrl #(
    parameter int SYNC_STAGES = 2,
    parameter int DEB_CYCLES  = 100000,
    parameter int LOCK_STABLE = 256,
    parameter int HOLD_CYCLES = 1024
) (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic       pll_locked_i,
    input  logic       btn_rst_n_i,
    input  logic       sw_rst_req_i,
    output logic       sys_rst_n_o,
    output logic       rst_done_o,
    output logic [1:0] rst_cause_o,
    output logic [7:0] rst_cnt_o
);
    import retrosoc_rst_pkg::*;

    localparam int LW = $clog2(LOCK_STABLE + 1);
    localparam int HW = $clog2(HOLD_CYCLES + 1);
    localparam logic [LW-1:0] LOCK_LAST = LW'(LOCK_STABLE - 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);

    rst_state_e             state_q, state_nxt;
    rst_cause_e             cause_q, cause_nxt;
    logic [7:0]             cnt_q, cnt_nxt;
    logic [LW-1:0]          lock_cnt_q, lock_cnt_nxt;
    logic [HW-1:0]          hold_cnt_q, hold_cnt_nxt;
    logic [SYNC_STAGES-1:0] lock_sync_q;
    logic                   lock_sync;
    logic                   btn_deb_n;
    logic                   sys_rst_n_q;
    logic                   done_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            lock_sync_q <= '0;
        end else begin
            lock_sync_q <= {lock_sync_q[SYNC_STAGES-2:0], pll_locked_i};
        end
    end

    assign lock_sync = lock_sync_q[SYNC_STAGES-1];

    retrosoc_rst_debounce #(
        .SYNC_STAGES(SYNC_STAGES),
        .DEB_CYCLES (DEB_CYCLES)
    ) u_debounce (
        .clk_i    (clk_i),
        .rst_n_i  (rst_n_i),
        .btn_raw_n(btn_rst_n_i),
        .btn_deb_n(btn_deb_n)
    );

    // Counters default to zero so every state entry starts a fresh count.
    always_comb begin
        state_nxt    = state_q;
        cause_nxt    = cause_q;
        cnt_nxt      = cnt_q;
        lock_cnt_nxt = '0;
        hold_cnt_nxt = '0;
        case (state_q)
            WAIT_LOCK: begin
                if (lock_sync) begin
                    if (lock_cnt_q == LOCK_LAST) begin
                        state_nxt = HOLD;
                    end else begin
                        lock_cnt_nxt = lock_cnt_q + 1'b1;
                    end
                end
            end
            HOLD: begin
                if (!lock_sync) begin
                    state_nxt = WAIT_LOCK;
                end else if (!btn_deb_n) begin
                    state_nxt = BTN_WAIT;
                end else if (hold_cnt_q == HOLD_LAST) begin
                    state_nxt = RUN;
                end else begin
                    hold_cnt_nxt = hold_cnt_q + 1'b1;
                end
            end
            BTN_WAIT: begin
                if (!lock_sync) begin
                    state_nxt = WAIT_LOCK;
                end else if (btn_deb_n) begin
                    state_nxt = HOLD;
                end
            end
            RUN: begin
                if (!lock_sync) begin
                    state_nxt = WAIT_LOCK;
                    cause_nxt = RST_LOCK;
                    cnt_nxt   = sat_inc(cnt_q);
                end else if (!btn_deb_n) begin
                    state_nxt = BTN_WAIT;
                    cause_nxt = RST_BTN;
                    cnt_nxt   = sat_inc(cnt_q);
                end else if (sw_rst_req_i) begin
                    state_nxt = HOLD;
                    cause_nxt = RST_SW;
                    cnt_nxt   = sat_inc(cnt_q);
                end
            end
            default: begin
                state_nxt = WAIT_LOCK;
            end
        endcase
    end

    // Outputs are registered from the next state so release and warm assertion
    // line up with the state change itself.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q     <= WAIT_LOCK;
            cause_q     <= RST_POR;
            cnt_q       <= '0;
            lock_cnt_q  <= '0;
            hold_cnt_q  <= '0;
            sys_rst_n_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_nxt;
            cause_q     <= cause_nxt;
            cnt_q       <= cnt_nxt;
            lock_cnt_q  <= lock_cnt_nxt;
            hold_cnt_q  <= hold_cnt_nxt;
            sys_rst_n_q <= (state_nxt == RUN);
            done_q      <= (state_nxt == RUN);
        end
    end

    assign sys_rst_n_o = sys_rst_n_q;
    assign rst_done_o  = done_q;
    assign rst_cause_o = cause_q;
    assign rst_cnt_o   = cnt_q;

endmodule

// File: tb/tb_retrosoc_rst_ctrl.sv
// Self-checking bench for retrosoc_rst_ctrl: directed scenarios plus random lock/button/sw
// traffic, every cycle compared against a behavioural model of the reset rules.
module tb_retrosoc_rst_ctrl;
    localparam int SYNC = 2;
    localparam int DEB  = 8;
    localparam int LOCK = 4;
    localparam int HOLD = 16;

    logic       clk_i = 1'b0;
    logic       rst_n_i;
    logic       pll_locked_i;
    logic       btn_rst_n_i;
    logic       sw_rst_req_i;
    logic       sys_rst_n_o;
    logic       rst_done_o;
    logic [1:0] rst_cause_o;
    logic [7:0] rst_cnt_o;

    int checks = 0;
    int errors = 0;

    always #5 clk_i = ~clk_i;

    retrosoc_rst_ctrl #(
        .SYNC_STAGES(SYNC),
        .DEB_CYCLES (DEB),
        .LOCK_STABLE(LOCK),
        .HOLD_CYCLES(HOLD)
    ) dut (
        .clk_i       (clk_i),
        .rst_n_i     (rst_n_i),
        .pll_locked_i(pll_locked_i),
        .btn_rst_n_i (btn_rst_n_i),
        .sw_rst_req_i(sw_rst_req_i),
        .sys_rst_n_o (sys_rst_n_o),
        .rst_done_o  (rst_done_o),
        .rst_cause_o (rst_cause_o),
        .rst_cnt_o   (rst_cnt_o)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, obs, exp);
        end
    endtask

    // Behavioural model: delay lines as queues, mode as a name, hold as cycles remaining.
    logic  lk_q[$];
    logic  bt_q[$];
    string mode;
    logic  m_deb;
    int    m_diff, m_run, m_hold_left, m_cause, m_cnt;
    logic  m_sys;

    function automatic void model_reset();
        lk_q.delete();
        bt_q.delete();
        for (int i = 0; i < SYNC; i++) begin
            lk_q.push_back(1'b0);
            bt_q.push_back(1'b1);
        end
        mode = "wait"; m_deb = 1'b1; m_diff = 0; m_run = 0; m_hold_left = 0;
        m_cause = 0; m_cnt = 0; m_sys = 1'b0;
    endfunction

    function automatic void warm(input string to, input int cause);
        mode    = to;
        m_cause = cause;
        m_cnt   = (m_cnt >= 255) ? 255 : m_cnt + 1;
        m_run   = 0;
        m_hold_left = HOLD;
    endfunction

    function automatic void model_step(input logic lk, input logic bt, input logic sw);
        logic ls, bs, d;
        ls = lk_q[0];
        bs = bt_q[0];
        d  = m_deb;
        lk_q.push_back(lk); void'(lk_q.pop_front());
        bt_q.push_back(bt); void'(bt_q.pop_front());
        if (bs == d) m_diff = 0;
        else begin
            m_diff++;
            if (m_diff == DEB) begin m_deb = bs; m_diff = 0; end
        end
        if (mode == "wait") begin
            if (ls) begin
                m_run++;
                if (m_run == LOCK) begin mode = "hold"; m_hold_left = HOLD; end
            end else m_run = 0;
        end else if (mode == "hold") begin
            if (!ls) begin mode = "wait"; m_run = 0; end
            else if (!d) mode = "btn";
            else begin
                m_hold_left--;
                if (m_hold_left == 0) mode = "run";
            end
        end else if (mode == "btn") begin
            if (!ls) begin mode = "wait"; m_run = 0; end
            else if (d) begin mode = "hold"; m_hold_left = HOLD; end
        end else begin
            if (!ls) warm("wait", 1);
            else if (!d) warm("btn", 2);
            else if (sw) warm("hold", 3);
        end
        m_sys = (mode == "run");
    endfunction

    task automatic step(input logic lk, input logic bt, input logic sw);
        pll_locked_i = lk;
        btn_rst_n_i  = bt;
        sw_rst_req_i = sw;
        model_step(lk, bt, sw);
        @(negedge clk_i);
        chk("sys_rst_n", int'(sys_rst_n_o), int'(m_sys));
        chk("rst_done", int'(rst_done_o), int'(m_sys));
        chk("rst_cause", int'(rst_cause_o), m_cause);
        chk("rst_cnt", int'(rst_cnt_o), m_cnt);
    endtask

    task automatic wait_sys(input logic lvl, input logic lk, input logic bt, output int n);
        n = 0;
        do begin
            step(lk, bt, 1'b0);
            n++;
        end while (sys_rst_n_o !== lvl && n < 300);
    endtask

    task automatic por_pulse();
        rst_n_i = 1'b0;
        model_reset();
        @(negedge clk_i);
        @(negedge clk_i);
        rst_n_i = 1'b1;
    endtask

    initial begin
        int n, low_n, seen_low;
        int lk_left, bt_left;
        logic lk_v, bt_v;

        rst_n_i = 1'b0; pll_locked_i = 1'b1; btn_rst_n_i = 1'b1; sw_rst_req_i = 1'b0;
        model_reset();
        repeat (3) @(negedge clk_i);
        chk("por_sys", int'(sys_rst_n_o), 0);
        chk("por_done", int'(rst_done_o), 0);
        chk("por_cause", int'(rst_cause_o), 0);
        chk("por_cnt", int'(rst_cnt_o), 0);

        // Lock already high at release
        rst_n_i = 1'b1;
        wait_sys(1'b1, 1'b1, 1'b1, n);
        chk("t1_release", n, SYNC + LOCK + HOLD);
        chk("t1_cause", int'(rst_cause_o), 0);
        chk("t1_cnt", int'(rst_cnt_o), 0);

        // One-cycle lock drop once the lock count has reached 3
        por_pulse();
        repeat (3) step(1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        wait_sys(1'b1, 1'b1, 1'b1, n);
        chk("t2_release", n + 4, SYNC + LOCK + HOLD + LOCK);

        // Short bounce ignored, long press resets
        repeat (10) step(1'b1, 1'b1, 1'b0);
        seen_low = 0;
        repeat (5) begin
            step(1'b1, 1'b0, 1'b0);
            if (sys_rst_n_o !== 1'b1) seen_low = 1;
        end
        repeat (20) begin
            step(1'b1, 1'b1, 1'b0);
            if (sys_rst_n_o !== 1'b1) seen_low = 1;
        end
        chk("t3_bounce", seen_low, 0);
        wait_sys(1'b0, 1'b1, 1'b0, n);
        chk("t3_press_fall", n, SYNC + DEB + 1);
        repeat (20 - n) step(1'b1, 1'b0, 1'b0);
        wait_sys(1'b1, 1'b1, 1'b1, n);
        chk("t3_release_rise", n, SYNC + DEB + 1 + HOLD);
        chk("t3_cause", int'(rst_cause_o), 2);
        chk("t3_cnt", int'(rst_cnt_o), 1);

        // Software request
        repeat (5) step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b1);
        low_n = (sys_rst_n_o === 1'b0) ? 1 : 0;
        while (sys_rst_n_o !== 1'b1 && low_n < 100) begin
            step(1'b1, 1'b1, 1'b0);
            if (sys_rst_n_o === 1'b0) low_n++;
        end
        chk("t4_low_cycles", low_n, HOLD);
        chk("t4_cause", int'(rst_cause_o), 3);
        chk("t4_cnt", int'(rst_cnt_o), 2);

        // Lock loss and sw request reach the FSM together
        repeat (5) step(1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b1);
        chk("t5_cause", int'(rst_cause_o), 1);
        chk("t5_cnt", int'(rst_cnt_o), 3);
        chk("t5_sys", int'(sys_rst_n_o), 0);
        wait_sys(1'b1, 1'b1, 1'b1, n);
        chk("t5_relock", n, SYNC + LOCK + HOLD);

        // Saturation, then async reset in the middle of HOLD
        repeat (300) begin
            step(1'b1, 1'b1, 1'b1);
            wait_sys(1'b1, 1'b1, 1'b1, n);
        end
        chk("t6_saturate", int'(rst_cnt_o), 255);
        step(1'b1, 1'b1, 1'b1);
        repeat (5) step(1'b1, 1'b1, 1'b0);
        #2 rst_n_i = 1'b0;
        #1;
        chk("t6_async_sys", int'(sys_rst_n_o), 0);
        chk("t6_async_done", int'(rst_done_o), 0);
        chk("t6_async_cause", int'(rst_cause_o), 0);
        chk("t6_async_cnt", int'(rst_cnt_o), 0);
        model_reset();
        @(negedge clk_i);
        rst_n_i = 1'b1;

        // Random traffic with run-length shaped lock and button activity
        lk_left = 0; bt_left = 0; lk_v = 1'b1; bt_v = 1'b1;
        repeat (6000) begin
            if (lk_left == 0) begin
                lk_v    = ~lk_v;
                lk_left = lk_v ? int'($urandom_range(30, 300)) : int'($urandom_range(1, 6));
            end
            if (bt_left == 0) begin
                bt_v    = ~bt_v;
                bt_left = bt_v ? int'($urandom_range(10, 200)) : int'($urandom_range(1, 25));
            end
            lk_left--;
            bt_left--;
            step(lk_v, bt_v, ($urandom_range(0, 29) == 0) ? 1'b1 : 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
